hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter MULT_CYCLES, default 5, multiply busy cycles (1..255).
REQ-003 Parameter DIV_CYCLES, default 10, divide busy cycles (1..255).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 D_Rs, D_Rt  input  REG_AW each  D-stage source registers.
REQ-007 D_TuseRs, D_TuseRt  input  2 each  cycles until D operand needed; 3 = operand unused.
REQ-008 D_MdUse  input  1  D instruction reads or writes HI/LO or starts mult/div.
REQ-009 E_Rs, E_Rt, E_WriteReg  input  REG_AW each  E-stage sources and destination.
REQ-010 E_WriteEnable  input  1; E_Tnew  input  2  cycles until E result exists.
REQ-011 E_MdStart  input  1  mult/div issued in E this cycle; E_MdIsDiv  input  1  1 = divide.
REQ-012 M_Rt, M_WriteReg  input  REG_AW; M_WriteEnable  input  1; M_Tnew  input  2.
REQ-013 W_WriteReg  input  REG_AW; W_WriteEnable  input  1.
REQ-014 ForwardAD, ForwardBD, ForwardAE, ForwardBE  output  2 each  0 = RF/pipe, 1 = W, 2 = M.
REQ-015 ForwardBM  output  1  forward W result to M store data.
REQ-016 Stall  output  1  freeze F/D, bubble E.
REQ-017 MdBusy  output  1  mult/div unit busy.
REQ-018 StallCount  output  32  stall-cycle counter (see Configuration).

Function
REQ-019 Match(src, dst, we) SHALL be we & (src != 0) & (src == dst).
REQ-020 ForwardXD/XE SHALL select 2 on Match with M and M_Tnew == 0, else 1 on Match with W, else 0; M has priority.
REQ-021 ForwardBM SHALL be 1 iff Match(M_Rt, W_WriteReg, W_WriteEnable).
REQ-022 Data stall SHALL assert iff, for Rs or Rt with Tuse != 3: Match with E and Tuse < E_Tnew, or Match with M and Tuse < M_Tnew.
REQ-023 Forwarding and data stall SHALL be combinational (zero latency).
REQ-024 Internal 8-bit counter md_cnt; on E_MdStart load MULT_CYCLES or DIV_CYCLES per E_MdIsDiv; else decrement while nonzero.
REQ-025 E_MdStart while md_cnt != 0 SHALL reload (latest start wins).
REQ-026 MdBusy SHALL equal E_MdStart | (md_cnt != 0).
REQ-027 Md stall SHALL be D_MdUse & MdBusy.
REQ-028 Stall SHALL be data stall | md stall.
REQ-029 md_cnt SHALL reach 0 exactly N cycles after the start edge (N = loaded value); MdBusy low from that cycle.

Reset
REQ-030 reset high at an edge SHALL clear md_cnt and StallCount, aborting any in-flight mult/div tracking.
REQ-031 During and after reset, with all inputs 0, all outputs SHALL be 0.
REQ-032 reset SHALL take priority over simultaneous E_MdStart.

Configuration
REQ-033 Macro HAZARD_CTRL_PERF_EN defined: StallCount increments by 1 at each edge where Stall = 1, saturates at 32'hFFFFFFFF, cleared by reset.
REQ-034 Macro undefined: StallCount port present, constant 0, no counter flops.

Verification
REQ-035 Load-use: E_WriteReg=8, E_WriteEnable=1, E_Tnew=2, D_Rs=8, D_TuseRs=1 -> Stall=1; E_Tnew=1 -> Stall=0.
REQ-036 Priority: M_WriteReg=W_WriteReg=5, both enabled, M_Tnew=0, E_Rs=5 -> ForwardAE=2; M_WriteEnable=0 -> 1; register 0 -> 0.
REQ-037 Mult: E_MdStart=1, E_MdIsDiv=0, D_MdUse=1 held -> MdBusy and Stall high 6 cycles (start + 5), low on 7th.
REQ-038 Div reload: DIV start, MULT start 3 cycles later -> MdBusy low exactly 5 cycles after second start.
REQ-039 Reset mid-divide: reset at cycle 4 of 10 -> MdBusy=0 next cycle, StallCount=0.
REQ-040 Perf: PERF_EN defined, Stall forced 7 cycles -> StallCount=7; undefined -> StallCount=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard unit. It provides operand forwarding selects,
//            data/mult-div stall generation and mult/div busy tracking.
//            Optional stall-cycle counter, enabled by HAZARD_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_Rs,
    input  logic [REG_AW-1:0] D_Rt,
    input  logic [1:0]        D_TuseRs,
    input  logic [1:0]        D_TuseRt,
    input  logic              D_MdUse,
    input  logic [REG_AW-1:0] E_Rs,
    input  logic [REG_AW-1:0] E_Rt,
    input  logic [REG_AW-1:0] E_WriteReg,
    input  logic              E_WriteEnable,
    input  logic [1:0]        E_Tnew,
    input  logic              E_MdStart,
    input  logic              E_MdIsDiv,
    input  logic [REG_AW-1:0] M_Rt,
    input  logic [REG_AW-1:0] M_WriteReg,
    input  logic              M_WriteEnable,
    input  logic [1:0]        M_Tnew,
    input  logic [REG_AW-1:0] W_WriteReg,
    input  logic              W_WriteEnable,
    output logic [1:0]        ForwardAD,
    output logic [1:0]        ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardBM,
    output logic              Stall,
    output logic              MdBusy,
    output logic [31:0]       StallCount
);

    localparam logic [7:0] c_MULT_CYCLES = 8'(MULT_CYCLES);
    localparam logic [7:0] c_DIV_CYCLES  = 8'(DIV_CYCLES);
    localparam logic [1:0] c_TUSE_NONE   = 2'd3;

    function automatic logic f_match(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              we);
        return we && (src != '0) && (src == dst);
    endfunction

    // M only forwards once its result exists; W always holds a final value.
    function automatic logic [1:0] f_fwdSel(input logic [REG_AW-1:0] src);
        if (f_match(src, M_WriteReg, M_WriteEnable) && (M_Tnew == 2'd0))
            return 2'd2;
        else if (f_match(src, W_WriteReg, W_WriteEnable))
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic f_needStall(input logic [REG_AW-1:0] src,
                                         input logic [1:0]        tuse);
        return (tuse != c_TUSE_NONE) &&
               ((f_match(src, E_WriteReg, E_WriteEnable) && (tuse < E_Tnew)) ||
                (f_match(src, M_WriteReg, M_WriteEnable) && (tuse < M_Tnew)));
    endfunction

    logic [7:0] r_mdCnt;
    logic       w_dataStall;
    logic       w_mdBusy;
    logic       w_stall;

    assign ForwardAD = f_fwdSel(D_Rs);
    assign ForwardBD = f_fwdSel(D_Rt);
    assign ForwardAE = f_fwdSel(E_Rs);
    assign ForwardBE = f_fwdSel(E_Rt);
    assign ForwardBM = f_match(M_Rt, W_WriteReg, W_WriteEnable);

    assign w_dataStall = f_needStall(D_Rs, D_TuseRs) || f_needStall(D_Rt, D_TuseRt);
    assign w_mdBusy    = E_MdStart || (r_mdCnt != 8'd0);
    assign w_stall     = w_dataStall || (D_MdUse && w_mdBusy);

    assign MdBusy = w_mdBusy;
    assign Stall  = w_stall;

    // A new start always reloads, so the latest issued operation sets the busy window.
    always_ff @(posedge clk) begin
        if (reset)
            r_mdCnt <= 8'd0;
        else if (E_MdStart)
            r_mdCnt <= E_MdIsDiv ? c_DIV_CYCLES : c_MULT_CYCLES;
        else if (r_mdCnt != 8'd0)
            r_mdCnt <= r_mdCnt - 8'd1;
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] r_stallCount;

    always_ff @(posedge clk) begin
        if (reset)
            r_stallCount <= 32'd0;
        else if (w_stall && (r_stallCount != 32'hFFFF_FFFF))
            r_stallCount <= r_stallCount + 32'd1;
    end

    assign StallCount = r_stallCount;
`else
    assign StallCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: vector table, directed
//            mult/div/reset sequences and randomized model comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_AW   = 5;
    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;
`ifdef HAZARD_CTRL_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [c_AW-1:0] D_Rs, D_Rt, E_Rs, E_Rt, E_WriteReg, M_Rt, M_WriteReg, W_WriteReg;
    logic [1:0]      D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
    logic            D_MdUse, E_WriteEnable, E_MdStart, E_MdIsDiv, M_WriteEnable, W_WriteEnable;
    logic [1:0]      ForwardAD, ForwardBD, ForwardAE, ForwardBE;
    logic            ForwardBM, Stall, MdBusy;
    logic [31:0]     StallCount;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.REG_AW(c_AW), .MULT_CYCLES(c_MULT), .DIV_CYCLES(c_DIV)) dut (
        .clk(clk), .reset(reset),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt), .D_MdUse(D_MdUse),
        .E_Rs(E_Rs), .E_Rt(E_Rt), .E_WriteReg(E_WriteReg), .E_WriteEnable(E_WriteEnable),
        .E_Tnew(E_Tnew), .E_MdStart(E_MdStart), .E_MdIsDiv(E_MdIsDiv),
        .M_Rt(M_Rt), .M_WriteReg(M_WriteReg), .M_WriteEnable(M_WriteEnable), .M_Tnew(M_Tnew),
        .W_WriteReg(W_WriteReg), .W_WriteEnable(W_WriteEnable),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardBM(ForwardBM), .Stall(Stall), .MdBusy(MdBusy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_AW-1:0] dRs, dRt, eRs, eRt, eWr, mRt, mWr, wWr;
        logic [1:0]      tuseRs, tuseRt, eTnew, mTnew;
        logic            eWe, mWe, wWe;
        logic [1:0]      xAD, xBD, xAE, xBE;
        logic            xBM, xStall;
    } vec_t;

    vec_t vq[$];

    // Reference model state: the cycle index and the first cycle the unit is idle.
    longint cyc       = 0;
    longint busyUntil = 0;
    longint stallCnt  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        D_Rs = '0; D_Rt = '0; E_Rs = '0; E_Rt = '0; E_WriteReg = '0;
        M_Rt = '0; M_WriteReg = '0; W_WriteReg = '0;
        D_TuseRs = 2'd3; D_TuseRt = 2'd3; E_Tnew = '0; M_Tnew = '0;
        D_MdUse = 0; E_WriteEnable = 0; E_MdStart = 0; E_MdIsDiv = 0;
        M_WriteEnable = 0; W_WriteEnable = 0;
    endtask

    function automatic logic [1:0] mFwd(input logic [c_AW-1:0] src);
        if (src != 0 && M_WriteEnable && src == M_WriteReg && M_Tnew == 0) return 2'd2;
        if (src != 0 && W_WriteEnable && src == W_WriteReg) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic mHaz(input logic [c_AW-1:0] src, input logic [1:0] tuse);
        if (tuse == 3 || src == 0) return 1'b0;
        return (E_WriteEnable && src == E_WriteReg && tuse < E_Tnew) ||
               (M_WriteEnable && src == M_WriteReg && tuse < M_Tnew);
    endfunction

    function automatic logic mBusy();
        return E_MdStart || (cyc < busyUntil);
    endfunction

    function automatic logic mStall();
        return mHaz(D_Rs, D_TuseRs) || mHaz(D_Rt, D_TuseRt) || (D_MdUse && mBusy());
    endfunction

    task automatic modelCheck();
        chk("rnd_fwdAD", ForwardAD, mFwd(D_Rs));
        chk("rnd_fwdBD", ForwardBD, mFwd(D_Rt));
        chk("rnd_fwdAE", ForwardAE, mFwd(E_Rs));
        chk("rnd_fwdBE", ForwardBE, mFwd(E_Rt));
        chk("rnd_fwdBM", ForwardBM, (M_Rt != 0) && W_WriteEnable && (M_Rt == W_WriteReg));
        chk("rnd_mdBusy", MdBusy, mBusy());
        chk("rnd_stall", Stall, mStall());
        chk("rnd_stallCount", StallCount, c_PERF ? stallCnt : 0);
    endtask

    // One clock edge, with the model advanced on the inputs held across it.
    task automatic step();
        logic s;
        s = mStall();
        @(posedge clk);
        if (reset) begin
            busyUntil = 0;
            stallCnt  = 0;
        end else begin
            if (s && stallCnt != 64'hFFFF_FFFF) stallCnt++;
            if (E_MdStart) busyUntil = cyc + (E_MdIsDiv ? c_DIV : c_MULT) + 1;
        end
        cyc++;
        #1;
    endtask

    task automatic addVec(input vec_t v);
        vq.push_back(v);
    endtask

    initial begin
        vec_t v;
        idle();
        reset = 1;

        // Reset state with all inputs zero.
        D_TuseRs = 0; D_TuseRt = 0;
        step(); step();
        chk("rst_fwdAD", ForwardAD, 0); chk("rst_fwdBE", ForwardBE, 0);
        chk("rst_fwdBM", ForwardBM, 0); chk("rst_stall", Stall, 0);
        chk("rst_mdBusy", MdBusy, 0);   chk("rst_stallCount", StallCount, 0);
        reset = 0;
        idle();
        step();

        // Vector table: {dRs,dRt,eRs,eRt,eWr,mRt,mWr,wWr,tuses,tnews,wes | expected}
        v = '0; v.tuseRs = 3; v.tuseRt = 3;
        v.eWr = 8; v.eWe = 1; v.eTnew = 2; v.dRs = 8; v.tuseRs = 1; v.xStall = 1; addVec(v);
        v.eTnew = 1; v.xStall = 0; addVec(v);
        v = '0; v.tuseRs = 3; v.tuseRt = 3;
        v.mWr = 5; v.wWr = 5; v.mWe = 1; v.wWe = 1; v.eRs = 5; v.xAE = 2; addVec(v);
        v.mWe = 0; v.xAE = 1; addVec(v);
        v.mWe = 1; v.mWr = 0; v.wWr = 0; v.eRs = 0; v.xAE = 0; addVec(v);
        v = '0; v.tuseRs = 3; v.tuseRt = 3;
        v.mWr = 5; v.mWe = 1; v.mTnew = 1; v.wWr = 5; v.wWe = 1; v.eRt = 5; v.xBE = 1; addVec(v);
        v = '0; v.tuseRs = 3; v.tuseRt = 3;
        v.mRt = 7; v.wWr = 7; v.wWe = 1; v.dRt = 7; v.xBM = 1; v.xBD = 1; addVec(v);
        v = '0; v.tuseRs = 3; v.tuseRt = 3;
        v.eWr = 9; v.eWe = 1; v.eTnew = 2; v.dRt = 9; addVec(v);
        v = '0; v.tuseRs = 3;
        v.mWr = 4; v.mWe = 1; v.mTnew = 1; v.dRt = 4; v.tuseRt = 0; v.xStall = 1; addVec(v);
        v = '0; v.tuseRt = 3;
        v.eWr = 3; v.eWe = 1; v.eTnew = 2; v.dRs = 3; v.tuseRs = 2; addVec(v);
        v.eWe = 0; v.tuseRs = 0; addVec(v);
        v = '0; v.tuseRt = 3;
        v.mWr = 6; v.mWe = 1; v.mTnew = 0; v.dRs = 6; v.tuseRs = 0; v.xAD = 2; addVec(v);

        foreach (vq[i]) begin
            D_Rs = vq[i].dRs; D_Rt = vq[i].dRt; E_Rs = vq[i].eRs; E_Rt = vq[i].eRt;
            E_WriteReg = vq[i].eWr; M_Rt = vq[i].mRt; M_WriteReg = vq[i].mWr;
            W_WriteReg = vq[i].wWr; D_TuseRs = vq[i].tuseRs; D_TuseRt = vq[i].tuseRt;
            E_Tnew = vq[i].eTnew; M_Tnew = vq[i].mTnew; E_WriteEnable = vq[i].eWe;
            M_WriteEnable = vq[i].mWe; W_WriteEnable = vq[i].wWe;
            #1;
            chk($sformatf("vec%0d_fwdAD", i), ForwardAD, vq[i].xAD);
            chk($sformatf("vec%0d_fwdBD", i), ForwardBD, vq[i].xBD);
            chk($sformatf("vec%0d_fwdAE", i), ForwardAE, vq[i].xAE);
            chk($sformatf("vec%0d_fwdBE", i), ForwardBE, vq[i].xBE);
            chk($sformatf("vec%0d_fwdBM", i), ForwardBM, vq[i].xBM);
            chk($sformatf("vec%0d_stall", i), Stall, vq[i].xStall);
        end

        // Multiply: start + 5 busy cycles, idle on the 7th.
        idle(); reset = 1; step(); reset = 0;
        E_MdStart = 1; E_MdIsDiv = 0; D_MdUse = 1; #1;
        chk("mult_busy_c0", MdBusy, 1); chk("mult_stall_c0", Stall, 1);
        step(); E_MdStart = 0; #1;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("mult_busy_c%0d", k), MdBusy, 1);
            chk($sformatf("mult_stall_c%0d", k), Stall, 1);
            step();
        end
        chk("mult_busy_c6", MdBusy, 0); chk("mult_stall_c6", Stall, 0);

        // Divide, then a multiply 3 cycles later reloads the count.
        idle(); step();
        E_MdStart = 1; E_MdIsDiv = 1; step(); E_MdStart = 0;
        step(); step();
        chk("reload_busy_before", MdBusy, 1);
        E_MdStart = 1; E_MdIsDiv = 0; step(); E_MdStart = 0; #1;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("reload_busy_c%0d", k), MdBusy, 1);
            step();
        end
        chk("reload_busy_after", MdBusy, 0);

        // Reset in the middle of a divide, and reset beating a start.
        idle(); step();
        E_MdStart = 1; E_MdIsDiv = 1; step(); E_MdStart = 0;
        step(); step(); step();
        chk("rdiv_busy_mid", MdBusy, 1);
        reset = 1; step(); reset = 0; #1;
        chk("rdiv_busy", MdBusy, 0); chk("rdiv_stallCount", StallCount, 0);
        reset = 1; E_MdStart = 1; E_MdIsDiv = 1; step();
        reset = 0; E_MdStart = 0; #1;
        chk("rst_vs_start_busy", MdBusy, 0);

        // Seven forced stall cycles.
        idle(); reset = 1; step(); reset = 0;
        E_WriteReg = 8; E_WriteEnable = 1; E_Tnew = 2; D_Rs = 8; D_TuseRs = 1;
        for (int k = 0; k < 7; k++) step();
        idle(); #1;
        chk("perf_stallCount", StallCount, c_PERF ? 7 : 0);
        step();
        chk("perf_stallCount_hold", StallCount, c_PERF ? 7 : 0);

        // Randomized traffic against the reference model.
        idle(); reset = 1; step(); reset = 0;
        for (int n = 0; n < 3000; n++) begin
            D_Rs = c_AW'($urandom_range(0, 3)); D_Rt = c_AW'($urandom_range(0, 3));
            E_Rs = c_AW'($urandom_range(0, 3)); E_Rt = c_AW'($urandom_range(0, 3));
            E_WriteReg = c_AW'($urandom_range(0, 3)); M_Rt = c_AW'($urandom_range(0, 3));
            M_WriteReg = c_AW'($urandom_range(0, 3)); W_WriteReg = c_AW'($urandom_range(0, 3));
            D_TuseRs = 2'($urandom_range(0, 3)); D_TuseRt = 2'($urandom_range(0, 3));
            E_Tnew = 2'($urandom_range(0, 3)); M_Tnew = 2'($urandom_range(0, 3));
            E_WriteEnable = 1'($urandom_range(0, 1)); M_WriteEnable = 1'($urandom_range(0, 1));
            W_WriteEnable = 1'($urandom_range(0, 1));
            D_MdUse = ($urandom_range(0, 2) == 0);
            E_MdStart = ($urandom_range(0, 11) == 0);
            E_MdIsDiv = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 99) == 0);
            #1;
            modelCheck();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
